shift_reg_ctrl: RTL and testbench
=================================

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter WIDTH, default 8: shift word width; legal values are 2 and above.
REQ-003 Parameter LSB_FIRST, default 0: 0 shifts out MSB first; 1 shifts out LSB first.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port din, input, WIDTH: parallel word to serialize.
REQ-007 Port din_valid, input, 1: din is presented.
REQ-008 Port din_ready, output, 1: the controller can accept a word.
REQ-009 Port abort, input, 1: cancels the transfer in progress.
REQ-010 Port sout, output, 1: serial data bit.
REQ-011 Port sout_valid, output, 1: sout carries a valid bit.
REQ-012 Port busy, output, 1: a transfer is in progress.
REQ-013 Port done, output, 1: one-cycle pulse when a transfer completes normally.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, PARITY and DONE; all outputs SHALL be registered.
REQ-015 din_ready SHALL be 1 only in IDLE; a word is accepted on a clk edge when din_valid and din_ready are both 1.
REQ-016 On accept, the block SHALL capture din into the shift register, load the bit counter with WIDTH-1 and go IDLE->SHIFT.
REQ-017 In SHIFT, every cycle SHALL:
- drive sout with the current bit (MSB when LSB_FIRST=0, LSB when LSB_FIRST=1);
- hold sout_valid=1;
- shift the register by one and decrement the counter.
REQ-018 The first bit SHALL appear on sout in the cycle after accept, and exactly WIDTH data bits SHALL follow in consecutive cycles.
REQ-019 When the counter is 0 in SHIFT, the next state SHALL be PARITY if the parity macro is defined, otherwise DONE.
REQ-020 DONE SHALL last one cycle with done=1, sout_valid=0 and din_ready=0, then return to IDLE.
REQ-021 busy SHALL be 1 in SHIFT, PARITY and DONE, and 0 in IDLE.
REQ-022 sout SHALL be 0 whenever sout_valid is 0.
REQ-023 Abort in SHIFT or PARITY SHALL force IDLE on the next edge, with sout_valid=0 and no done pulse.
REQ-024 Abort in IDLE or DONE SHALL be ignored; abort and din_valid together in IDLE SHALL accept the word.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.
REQ-026 din SHALL be ignored outside IDLE; the captured word SHALL not change mid-transfer.

Reset
REQ-027 rst SHALL have priority over all inputs, including during a transfer.
REQ-028 Reset state: FSM=IDLE, din_ready=1, sout=0, sout_valid=0, busy=0, done=0, shift register=0, counter=0.

Configuration
REQ-029 With SHIFT_REG_CTRL_PARITY_EN defined, the block SHALL:
- emit one extra sout_valid cycle in PARITY, after the last data bit, carrying the even parity (XOR) of the captured word;
- give a transfer length of WIDTH+1 valid bits.
REQ-030 Without SHIFT_REG_CTRL_PARITY_EN, the PARITY state and parity logic SHALL be absent and SHIFT SHALL go directly to DONE.

Structure
REQ-031 The shared package (shift_ctrl_pkg) SHALL hold the state encoding constants (IDLE=0, SHIFT=1, PARITY=2, DONE=3) and the state width.
REQ-032 The shift datapath SHALL be a sub-module, shift_reg_core, with ports clk, rst, load, shift, din and bit_out; the FSM and counter stay in shift_reg_ctrl.

Verification
REQ-033 Reset: hold rst for 2 cycles -> din_ready=1, busy=0, sout_valid=0, sout=0, done=0.
REQ-034 MSB first: WIDTH=8, LSB_FIRST=0, din=8'hA5 accepted at edge t -> sout 1,0,1,0,0,1,0,1 in cycles t+1..t+8, done=1 at t+9, din_ready=1 at t+10.
REQ-035 LSB first: LSB_FIRST=1, din=8'h01 -> sout 1 followed by seven 0s, then done.
REQ-036 Abort: assert abort in the cycle the 3rd bit is valid -> sout_valid=0 and din_ready=1 on the next cycle, no done pulse.
REQ-037 Back-to-back and parity:
- din_valid held high with 8'hFF then 8'h00 -> second word accepted only after DONE->IDLE, giving a 2-cycle gap with sout_valid=0;
- with SHIFT_REG_CTRL_PARITY_EN defined, din=8'h07 -> 9th valid bit = 1.
REQ-038 Reset mid-operation: assert rst during the 5th bit -> next cycle matches the REQ-028 reset state, no done pulse.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding for the shift_reg_ctrl serializer.
// Exports STATE_W (state register width) and state_t (IDLE=0, SHIFT=1, PARITY=2, DONE=3).
package shift_ctrl_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/shift_reg_core.sv
// shift_reg_core: loadable shift register whose output bit is a flop bit.
// Ports: clk, rst (sync, active high); load (capture din, wins over shift);
// shift (advance one bit, zero fill); din [WIDTH-1:0]; bit_out (MSB, or LSB when LSB_FIRST).
module shift_reg_core #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d  = load ? din : shift ? (LSB_FIRST ? data_q >> 1 : data_q << 1) : data_q;
        bit_out = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end
endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: parallel-to-serial controller with abort and optional even parity bit.
// Ports: clk, rst (sync, active high); din [WIDTH-1:0], din_valid, din_ready (word handshake);
// abort (cancel transfer); sout, sout_valid (serial stream); busy; done (completion pulse).
// Optional feature: define SHIFT_REG_CTRL_PARITY_EN to append an even parity bit.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             din_ready_q, din_ready_d;
    logic             load, shift;
    logic [WIDTH-1:0] core_din;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic             par_q, par_d;
`endif

    // sout is the core's output flop; the register is zero-filled as it shifts
    // and cleared on abort, so sout reads 0 whenever no bit is valid.
    shift_reg_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .din     (core_din),
        .bit_out (sout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift    = 1'b0;
        core_din = din;
`ifdef SHIFT_REG_CTRL_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: if (din_valid) begin
                state_d = SHIFT;
                cnt_d   = CW'(WIDTH - 1);
                load    = 1'b1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                par_d   = ^din;
`endif
            end
            SHIFT: if (abort) begin
                state_d  = IDLE;
                cnt_d    = '0;
                load     = 1'b1;
                core_din = '0;
            end else if (cnt_q == '0) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
                // parity goes into the output bit position so it follows the last data bit
                state_d  = PARITY;
                load     = 1'b1;
                core_din = LSB_FIRST ? WIDTH'(par_q) : {par_q, {(WIDTH-1){1'b0}}};
`else
                state_d  = DONE;
                shift    = 1'b1;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
                shift = 1'b1;
            end
`ifdef SHIFT_REG_CTRL_PARITY_EN
            PARITY: begin
                state_d  = abort ? IDLE : DONE;
                load     = 1'b1;
                core_din = '0;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sout_valid_d = (state_d == SHIFT) || (state_d == PARITY);
        busy_d       = state_d != IDLE;
        done_d       = state_d == DONE;
        din_ready_d  = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            din_ready_q  <= 1'b1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            din_ready_q  <= din_ready_d;
`ifdef SHIFT_REG_CTRL_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign din_ready  = din_ready_q;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: directed bench driving an MSB-first and an LSB-first instance in parallel.
module tb_shift_reg_ctrl;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       abort = 1'b0;
    logic       din_ready_m, sout_m, sout_valid_m, busy_m, done_m;
    logic       din_ready_l, sout_l, sout_valid_l, busy_l, done_l;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
        .abort(abort), .sout(sout_m), .sout_valid(sout_valid_m), .busy(busy_m), .done(done_m)
    );

    shift_reg_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .abort(abort), .sout(sout_l), .sout_valid(sout_valid_l), .busy(busy_l), .done(done_l)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq_m;
        logic [7:0] seq_l;
        logic       par;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        chk({tag, " din_ready_m"}, din_ready_m, 1);
        chk({tag, " din_ready_l"}, din_ready_l, 1);
        chk({tag, " busy"}, {busy_m, busy_l}, 0);
        chk({tag, " sout_valid"}, {sout_valid_m, sout_valid_l}, 0);
        chk({tag, " sout"}, {sout_m, sout_l}, 0);
        chk({tag, " done"}, {done_m, done_l}, 0);
    endtask

    // Present w for one accept edge; returns at the sample point of the first bit.
    task automatic send(input logic [7:0] w);
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = ~w;
    endtask

    task automatic run_vec(input vec_t v);
        send(v.din);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%02h valid bit%0d", v.din, k), {sout_valid_m, sout_valid_l, busy_m}, 3'b111);
            chk($sformatf("%02h msb bit%0d", v.din, k), sout_m, v.seq_m[7-k]);
            chk($sformatf("%02h lsb bit%0d", v.din, k), sout_l, v.seq_l[7-k]);
            @(negedge clk);
        end
        if (PAR) begin
            chk($sformatf("%02h parity valid", v.din), {sout_valid_m, sout_valid_l}, 2'b11);
            chk($sformatf("%02h parity bits", v.din), {sout_m, sout_l}, {v.par, v.par});
            @(negedge clk);
        end
        chk($sformatf("%02h done", v.din), {done_m, done_l}, 2'b11);
        chk($sformatf("%02h done cycle", v.din), {sout_valid_m, sout_m, din_ready_m, busy_m}, 4'b0001);
        @(negedge clk);
        idle_state($sformatf("%02h after", v.din));
    endtask

    initial begin
        bit seen;
        vt[0] = '{din: 8'hA5, seq_m: 8'hA5, seq_l: 8'hA5, par: 1'b0};
        vt[1] = '{din: 8'h01, seq_m: 8'h01, seq_l: 8'h80, par: 1'b1};
        vt[2] = '{din: 8'h07, seq_m: 8'h07, seq_l: 8'hE0, par: 1'b1};
        vt[3] = '{din: 8'h96, seq_m: 8'h96, seq_l: 8'h69, par: 1'b0};
        vt[4] = '{din: 8'h80, seq_m: 8'h80, seq_l: 8'h01, par: 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_state("reset held");
        rst = 1'b0;
        @(negedge clk);
        idle_state("reset released");

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // abort while the 3rd bit is on sout
        send(8'hA5);
        repeat (2) @(negedge clk);
        chk("abort 3rd bit", {sout_valid_m, sout_m}, 2'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle_state("after abort");
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= done_m | done_l | sout_valid_m;
        end
        chk("no done after abort", seen, 0);

        // abort with din_valid in IDLE still accepts; abort in DONE is ignored
        din = 8'h80; din_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; abort = 1'b0;
        chk("idle abort accepted", {sout_valid_m, sout_m, sout_l, busy_m}, 4'b1101);
        repeat (7 + (PAR ? 1 : 0) + 1) @(negedge clk);
        chk("idle abort done", {done_m, done_l}, 2'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle_state("abort in done");

        // reset during the 5th bit
        send(8'hFF);
        repeat (4) @(negedge clk);
        chk("5th bit valid", {sout_valid_m, sout_m}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_state("mid reset");
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= done_m | done_l | sout_valid_m;
        end
        chk("no done after reset", seen, 0);

        // back-to-back with din_valid held high
        din = 8'hFF; din_valid = 1'b1;
        @(negedge clk);
        din = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b ff bit%0d", k), {sout_valid_m, sout_m}, 2'b11);
            @(negedge clk);
        end
        if (PAR) begin
            chk("b2b ff parity", {sout_valid_m, sout_m}, 2'b10);
            @(negedge clk);
        end
        chk("b2b gap1 done", {sout_valid_m, done_m, din_ready_m}, 3'b010);
        @(negedge clk);
        chk("b2b gap2 idle", {sout_valid_m, done_m, din_ready_m}, 3'b001);
        @(negedge clk);
        din_valid = 1'b0;
        chk("b2b 00 first bit", {sout_valid_m, sout_m, sout_l}, 3'b100);
        repeat (12) @(negedge clk);
        idle_state("b2b end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
